// File: rtl/i2c_pkg.sv
// Shared I2C command encodings and byte-sequencer state type; also used by the tap generator.
// Combinational helpers only: no latency, no flow control.
package i2c_pkg;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_1     = 3'd2;
    localparam logic [2:0] CMD_0     = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;

    localparam logic [2:0] BIT_CNT_LOAD = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    function automatic logic [2:0] data_cmd(input logic bit_val);
        return bit_val ? CMD_1 : CMD_0;
    endfunction

endpackage

// File: rtl/i2c_byte_cmd_gen_if.sv
// Byte request, bit-command and status signals of the I2C byte command sequencer.
// slave = the sequencer itself; master = its upstream controller and downstream tap generator.
interface i2c_byte_cmd_gen_if;

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       byte_start;
    logic       byte_stop;
    logic       byte_ready;
    logic       cmd_vld;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       busy;
    logic       done;

    modport slave (
        input  byte_vld,
        input  byte_data,
        input  byte_start,
        input  byte_stop,
        output byte_ready,
        output cmd_vld,
        output cmd,
        input  cmd_ready,
        output busy,
        output done
    );

    modport master (
        output byte_vld,
        output byte_data,
        output byte_start,
        output byte_stop,
        input  byte_ready,
        input  cmd_vld,
        input  cmd,
        output cmd_ready,
        input  busy,
        input  done
    );

endinterface

// File: rtl/i2c_byte_cmd_gen.sv
// Expands one byte (+ optional START/STOP) into 9-11 bit commands; first command 1 cycle after accept,
// one idle cycle after each accepted command; cmd_ready low holds cmd/cmd_vld/state frozen.
module i2c_byte_cmd_gen
    import i2c_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    i2c_byte_cmd_gen_if.slave bus
);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       byte_ready_q, byte_ready_d;
    logic       cmd_vld_q, cmd_vld_d;
    logic [2:0] cmd_q, cmd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       byte_xfer;
    logic       cmd_acc;
    logic       issuing;
    logic [2:0] state_cmd;

    assign byte_xfer = bus.byte_vld && byte_ready_q;
    assign cmd_acc   = cmd_vld_q && bus.cmd_ready;

    always_comb begin
        state_cmd = CMD_NONE;
        issuing   = 1'b1;
        case (state_q)
            ST_START: state_cmd = CMD_START;
            ST_BIT:   state_cmd = data_cmd(shreg_q[7]);
            ST_ACK:   state_cmd = CMD_1;
            ST_STOP:  state_cmd = CMD_STOP;
            default:  issuing   = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        stop_d       = stop_q;
        byte_ready_d = byte_ready_q;
        cmd_vld_d    = cmd_vld_q;
        cmd_d        = cmd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                byte_ready_d = 1'b1;
                busy_d       = 1'b0;
                if (byte_xfer) begin
                    shreg_d      = bus.byte_data;
                    start_d      = bus.byte_start;
                    stop_d       = bus.byte_stop;
                    cnt_d        = BIT_CNT_LOAD;
                    byte_ready_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = bus.byte_start ? ST_START : ST_BIT;
                end
            end
            ST_START: begin
                if (cmd_acc) begin
                    state_d = ST_BIT;
                end
            end
            ST_BIT: begin
                if (cmd_acc) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                // ACK is only a released-SDA slot here; the slave response is judged elsewhere
                if (cmd_acc) begin
                    state_d = stop_q ? ST_STOP : ST_DONE;
                    done_d  = !stop_q;
                end
            end
            ST_STOP: begin
                if (cmd_acc) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                byte_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The dead cycle after each accept lines up with the tap generator's registered ready
        if (issuing) begin
            if (cmd_acc) begin
                cmd_vld_d = 1'b0;
            end else if (!cmd_vld_q) begin
                cmd_vld_d = 1'b1;
                cmd_d     = state_cmd;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= 8'd0;
            cnt_q        <= 3'd0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            cmd_vld_q    <= 1'b0;
            cmd_q        <= CMD_NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            byte_ready_q <= byte_ready_d;
            cmd_vld_q    <= cmd_vld_d;
            cmd_q        <= cmd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.cmd_vld    = cmd_vld_q;
    assign bus.cmd        = cmd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    a_cmd_hold: assert property (@(posedge clock) disable iff (rst)
        (cmd_vld_q && !bus.cmd_ready) |=> (cmd_vld_q && $stable(cmd_q)));

    a_ready_not_busy: assert property (@(posedge clock) disable iff (rst)
        byte_ready_q |-> !busy_q);

    a_done_quiet: assert property (@(posedge clock) disable iff (rst)
        done_q |-> (!cmd_vld_q && busy_q));

endmodule

// File: tb/tb_i2c_byte_cmd_gen.sv
// Directed + random-backpressure bench for i2c_byte_cmd_gen with a queue-based command model.
module tb_i2c_byte_cmd_gen;

    logic clock = 1'b0;
    logic rst;

    always #5 clock = ~clock;

    i2c_byte_cmd_gen_if bus();

    i2c_byte_cmd_gen dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 60)
                $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] exp_q[$];
    logic       m_rdy, m_busy, m_done, m_gap, m_vld;
    logic       m_xfer, m_acc, m_last, m_busy_nxt;
    int         want_cnt = 0;
    int         dut_acc  = 0;

    always @(negedge clock) begin
        if (rst) begin
            check("reset_outputs",
                  64'({bus.byte_ready, bus.cmd_vld, bus.cmd, bus.busy, bus.done}), 64'd0);
            exp_q.delete();
            m_rdy   = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_gap   = 1'b0;
            dut_acc = 0;
        end else begin
            m_vld = (exp_q.size() > 0) && !m_gap;
            check("byte_ready", 64'(bus.byte_ready), 64'(m_rdy));
            check("busy",       64'(bus.busy),       64'(m_busy));
            check("done",       64'(bus.done),       64'(m_done));
            check("cmd_vld",    64'(bus.cmd_vld),    64'(m_vld));
            if (m_vld)
                check("cmd", 64'(bus.cmd), 64'(exp_q[0]));
            if (bus.done) begin
                check("cmds_per_byte", 64'(dut_acc), 64'(want_cnt));
                dut_acc = 0;
            end
            if (bus.cmd_vld && bus.cmd_ready)
                dut_acc++;

            m_xfer = bus.byte_vld && m_rdy;
            m_acc  = m_vld && bus.cmd_ready;
            if (m_acc)
                void'(exp_q.pop_front());
            m_last = m_acc && (exp_q.size() == 0);
            if (m_xfer) begin
                if (bus.byte_start)
                    exp_q.push_back(3'd1);
                for (int i = 7; i >= 0; i--)
                    exp_q.push_back(bus.byte_data[i] ? 3'd2 : 3'd3);
                exp_q.push_back(3'd2);
                if (bus.byte_stop)
                    exp_q.push_back(3'd4);
                want_cnt = 9 + int'(bus.byte_start) + int'(bus.byte_stop);
            end
            m_gap      = m_xfer || m_acc;
            m_busy_nxt = m_xfer ? 1'b1 : (m_done ? 1'b0 : m_busy);
            m_done     = m_last;
            m_busy     = m_busy_nxt;
            m_rdy      = !m_busy_nxt;
        end
    end

    // ---------------- accepted-command log ----------------
    logic [2:0] acc_log[$];
    int         done_cnt = 0;

    always @(negedge clock) begin
        if (!rst) begin
            if (bus.cmd_vld && bus.cmd_ready)
                acc_log.push_back(bus.cmd);
            if (bus.done)
                done_cnt++;
        end
    end

    // ---------------- cmd_ready driver ----------------
    logic rand_mode = 1'b0;
    int   stall_cnt = 0;

    initial begin
        bus.cmd_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (rand_mode) begin
                bus.cmd_ready = ($urandom_range(0, 9) < 7);
            end else if (stall_cnt > 0) begin
                bus.cmd_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.cmd_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (bus.byte_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check("byte_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic p);
        bus.byte_vld   = 1'b1;
        bus.byte_data  = d;
        bus.byte_start = s;
        bus.byte_stop  = p;
        wait_ready();
        @(posedge clock);
        #1;
        bus.byte_vld = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check("done_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
    endtask

    // one nibble per command, first command in the most significant used nibble
    task automatic check_log(input string name, input int n, input logic [47:0] seq);
        logic [47:0] act = '0;
        check({name, "_len"}, 64'(acc_log.size()), 64'(n));
        foreach (acc_log[i])
            if (i < 12)
                act = (act << 4) | 48'(acc_log[i]);
        check(name, 64'(act), 64'(seq));
    endtask

    int d0;
    int n_bits;

    initial begin
        rst            = 1'b1;
        bus.byte_vld   = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_start = 1'b0;
        bus.byte_stop  = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        check("ready_before_first_edge", 64'(bus.byte_ready), 64'd0);
        @(posedge clock);
        #1;
        check("ready_after_first_edge", 64'(bus.byte_ready), 64'd1);

        // framed byte
        acc_log.delete();
        d0 = done_cnt;
        send(8'hA5, 1'b1, 1'b1);
        wait_done();
        check_log("framed_a5", 11, 48'h12323323224);
        check("framed_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("framed_idle_after", 64'({bus.busy, bus.byte_ready}), 64'b01);

        // unframed byte
        acc_log.delete();
        send(8'h00, 1'b0, 1'b0);
        wait_done();
        check_log("unframed_00", 9, 48'h333333332);

        // backpressure on the first data bit
        acc_log.delete();
        send(8'h80, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.cmd_vld && bus.cmd == 3'd1)
                break;
        end
        stall_cnt = 6;
        @(posedge clock);
        @(negedge clock);
        repeat (5) begin
            @(negedge clock);
            check("stall_vld_ready", 64'({bus.cmd_vld, bus.cmd_ready}), 64'b10);
            check("stall_cmd", 64'(bus.cmd), 64'd2);
        end
        wait_done();
        check_log("backpressure_80", 10, 48'h1233333332);

        // reset during the 4th data bit
        acc_log.delete();
        send(8'hFF, 1'b0, 1'b0);
        n_bits = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.cmd_vld && n_bits == 3)
                break;
            if (bus.cmd_vld && bus.cmd_ready)
                n_bits++;
        end
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              64'({bus.byte_ready, bus.cmd_vld, bus.cmd, bus.busy, bus.done}), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 rst = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        acc_log.delete();
        send(8'h01, 1'b0, 1'b0);
        wait_done();
        check_log("after_reset_01", 9, 48'h333333322);

        // back-to-back with byte_vld held high
        acc_log.delete();
        d0 = done_cnt;
        bus.byte_vld   = 1'b1;
        bus.byte_data  = 8'h12;
        bus.byte_start = 1'b0;
        bus.byte_stop  = 1'b0;
        wait_ready();
        @(posedge clock);
        #1 bus.byte_data = 8'h34;
        wait_ready();
        check("b2b_done_before_second", 64'(done_cnt - d0), 64'd1);
        check_log("b2b_12", 9, 48'h333233232);
        acc_log.delete();
        @(posedge clock);
        #1 bus.byte_vld = 1'b0;
        wait_done();
        check_log("b2b_34", 9, 48'h332232332);

        // random cmd_ready over many random bytes
        rand_mode = 1'b1;
        d0 = done_cnt;
        for (int b = 0; b < 200; b++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done();
        end
        check("random_done_pulses", 64'(done_cnt - d0), 64'd200);
        rand_mode = 1'b0;
        repeat (5) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
